// File: rtl/regfile_access_arbiter.sv
// Round-robin sharing of one register file (write port + read port A) between NREQ requesters.
// Grant is combinational, issue is 1 cycle later, read data returns 2 cycles after grant; requesters hold req until granted.
module regfile_access_arbiter #(
   parameter int NREQ         = 4,
   parameter int AW           = 5,
   parameter int DW           = 32,
   parameter int ZERO_PROTECT = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ-1:0]    req_we,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_wdata,
   output logic [NREQ-1:0]    gnt,
   output logic [NREQ-1:0]    rvalid,
   output logic [DW-1:0]      rdata,
   output logic [AW-1:0]      rf_address_w,
   output logic               rf_enable_w,
   output logic [DW-1:0]      rf_in,
   output logic [AW-1:0]      rf_address_a,
   output logic               rf_enable_a,
   output logic [AW-1:0]      rf_address_b,
   output logic               rf_enable_b,
   input  logic [DW-1:0]      rf_out_a
);

   logic [2:0]      rr_ptr_q, rr_ptr_d;
   logic [7:0]      req8, gnt8;
   logic [3:0]      idx;
   logic            gnt_any;
   logic [2:0]      gnt_idx;
   logic            sel_we;
   logic [AW-1:0]   sel_addr;
   logic [DW-1:0]   sel_wdata;
   logic            we_q, we_d, re_q, re_d;
   logic [AW-1:0]   wa_q, wa_d, ra_q, ra_d;
   logic [DW-1:0]   wd_q, wd_d;
   logic [2:0]      tag_q, tag_d;
   logic [NREQ-1:0] rvalid_q, rvalid_d;

   // Requests are padded to 8 so the rotating search index never selects out of range.
   always_comb begin
      req8 = '0;
      req8[NREQ-1:0] = req;
      gnt8 = '0;
      gnt_any = 1'b0;
      gnt_idx = '0;
      idx = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = {1'b0, rr_ptr_q} + 4'(k);
         if (idx >= 4'(NREQ)) idx = idx - 4'(NREQ);
         if (!gnt_any && rst_n && req8[idx[2:0]]) begin
            gnt_any = 1'b1;
            gnt_idx = idx[2:0];
            gnt8[idx[2:0]] = 1'b1;
         end
      end
   end

   assign gnt = gnt8[NREQ-1:0];

   always_comb begin
      sel_we = 1'b0;
      sel_addr = '0;
      sel_wdata = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt8[i]) begin
            sel_we = req_we[i];
            sel_addr = req_addr[i*AW +: AW];
            sel_wdata = req_wdata[i*DW +: DW];
         end
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (gnt_any) rr_ptr_d = (gnt_idx == 3'(NREQ-1)) ? 3'd0 : gnt_idx + 3'd1;
      // A protected write to address 0 still consumes its grant but never enables the RF.
      we_d = gnt_any && sel_we && !((ZERO_PROTECT != 0) && (sel_addr == '0));
      wa_d = wa_q;
      wd_d = wd_q;
      if (gnt_any && sel_we) begin
         wa_d = sel_addr;
         wd_d = sel_wdata;
      end
      re_d = gnt_any && !sel_we;
      ra_d = ra_q;
      tag_d = tag_q;
      if (re_d) begin
         ra_d = sel_addr;
         tag_d = gnt_idx;
      end
      rvalid_d = '0;
      for (int i = 0; i < NREQ; i++) rvalid_d[i] = re_q && (tag_q == 3'(i));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q <= '0;
         we_q     <= 1'b0;
         re_q     <= 1'b0;
         wa_q     <= '0;
         wd_q     <= '0;
         ra_q     <= '0;
         tag_q    <= '0;
         rvalid_q <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         we_q     <= we_d;
         re_q     <= re_d;
         wa_q     <= wa_d;
         wd_q     <= wd_d;
         ra_q     <= ra_d;
         tag_q    <= tag_d;
         rvalid_q <= rvalid_d;
      end
   end

   assign rf_enable_w  = we_q;
   assign rf_address_w = wa_q;
   assign rf_in        = wd_q;
   assign rf_enable_a  = re_q;
   assign rf_address_a = ra_q;
   assign rf_enable_b  = 1'b0;
   assign rf_address_b = '0;
   assign rvalid       = rvalid_q;
   assign rdata        = rf_out_a;

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Bench for regfile_access_arbiter: directed scenarios plus random traffic against a transaction-level model
// (one grant per cycle from a rotating start, writes land one cycle later, reads see the latest landed write).
module tb_regfile_access_arbiter;

   localparam int NREQ = 4;
   localparam int AW   = 5;
   localparam int DW   = 32;
   localparam int ZP   = 1;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [NREQ-1:0]    req, req_we, gnt, rvalid;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_wdata;
   logic [DW-1:0]      rdata, rf_in, rf_out_a;
   logic [AW-1:0]      rf_address_w, rf_address_a, rf_address_b;
   logic               rf_enable_w, rf_enable_a, rf_enable_b;

   regfile_access_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .ZERO_PROTECT(ZP)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .rf_address_w(rf_address_w), .rf_enable_w(rf_enable_w),
      .rf_in(rf_in), .rf_address_a(rf_address_a), .rf_enable_a(rf_enable_a), .rf_address_b(rf_address_b),
      .rf_enable_b(rf_enable_b), .rf_out_a(rf_out_a)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_val(input int i);
      return {16'hA5A5, 8'(i), ~8'(i)};
   endfunction

   // Behavioural register file attached to the DUT ports
   logic        tb_init;
   logic [31:0] rf_mem [32];
   always @(posedge clk) begin
      if (tb_init) begin
         for (int i = 0; i < 32; i++) rf_mem[i] <= init_val(i);
      end else begin
         if (rf_enable_w) rf_mem[rf_address_w] <= rf_in;
         if (rf_enable_a) rf_out_a <= rf_mem[rf_address_a];
      end
   end

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Requester state and reference model
   logic [NREQ-1:0] pend, pwe;
   logic [4:0]      paddr [NREQ];
   logic [31:0]     pdata [NREQ];
   logic [31:0]     model_mem [32];
   int              ptr;
   logic            s1_we, s1_re, s2_re;
   logic [4:0]      s1_waddr, s1_raddr;
   logic [31:0]     s1_wdata, s1_rdat, s2_rdat;
   int              s1_tag, s2_tag;
   logic [NREQ-1:0] obs_gnt, obs_rvalid;
   logic [31:0]     obs_rdata;

   task automatic drive();
      for (int i = 0; i < NREQ; i++) begin
         req[i] = pend[i];
         req_we[i] = pwe[i];
         req_addr[i*AW +: AW] = paddr[i];
         req_wdata[i*DW +: DW] = pdata[i];
      end
   endtask

   task automatic set_req(input int i, input logic we, input logic [4:0] a, input logic [31:0] d);
      pend[i] = 1'b1;
      pwe[i] = we;
      paddr[i] = a;
      pdata[i] = d;
   endtask

   // Called at a falling edge: checks this cycle's registered outputs, then grants for this cycle.
   task automatic step();
      int g;
      logic [NREQ-1:0] exp_g;
      chk_eq("rf_enable_w", rf_enable_w, s1_we);
      if (s1_we) begin
         chk_eq("rf_address_w", rf_address_w, s1_waddr);
         chk_eq("rf_in", rf_in, s1_wdata);
      end
      chk_eq("rf_enable_a", rf_enable_a, s1_re);
      if (s1_re) chk_eq("rf_address_a", rf_address_a, s1_raddr);
      chk_eq("rvalid", rvalid, s2_re ? (64'd1 << s2_tag) : 64'd0);
      if (s2_re) chk_eq("rdata", rdata, s2_rdat);
      chk_eq("port_b", {rf_enable_b, rf_address_b}, 64'd0);
      obs_rvalid = rvalid;
      obs_rdata = rdata;
      if (s1_we) model_mem[s1_waddr] = s1_wdata;
      s2_re = s1_re;
      s2_tag = s1_tag;
      s2_rdat = s1_rdat;
      s1_we = 1'b0;
      s1_re = 1'b0;
      drive();
      #1;
      g = -1;
      for (int k = 0; k < NREQ; k++)
         if (g < 0 && pend[(ptr + k) % NREQ]) g = (ptr + k) % NREQ;
      exp_g = (g < 0) ? '0 : NREQ'(1) << g;
      obs_gnt = gnt;
      chk_eq("gnt", gnt, exp_g);
      if (g >= 0) begin
         ptr = (g + 1) % NREQ;
         if (pwe[g]) begin
            s1_we = !(ZP != 0 && paddr[g] == 5'd0);
            s1_waddr = paddr[g];
            s1_wdata = pdata[g];
         end else begin
            s1_re = 1'b1;
            s1_raddr = paddr[g];
            s1_tag = g;
            s1_rdat = model_mem[paddr[g]];
         end
         pend[g] = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic drain(input int n);
      pend = '0;
      repeat (n) step();
   endtask

   task automatic chk_reset_outputs(input string pfx);
      chk_eq({pfx, "_gnt"}, gnt, 64'd0);
      chk_eq({pfx, "_rvalid"}, rvalid, 64'd0);
      chk_eq({pfx, "_en_w"}, rf_enable_w, 64'd0);
      chk_eq({pfx, "_en_a"}, rf_enable_a, 64'd0);
      chk_eq({pfx, "_addr_w"}, rf_address_w, 64'd0);
      chk_eq({pfx, "_addr_a"}, rf_address_a, 64'd0);
      chk_eq({pfx, "_rf_in"}, rf_in, 64'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      tb_init = 1'b1;
      pend = '0;
      pwe = '0;
      for (int i = 0; i < NREQ; i++) begin
         paddr[i] = '0;
         pdata[i] = '0;
      end
      for (int i = 0; i < 32; i++) model_mem[i] = init_val(i);
      ptr = 0;
      s1_we = 0; s1_re = 0; s2_re = 0; s1_tag = 0; s2_tag = 0;
      s1_waddr = '0; s1_raddr = '0; s1_wdata = '0; s1_rdat = '0; s2_rdat = '0;

      // Reset with all requests raised: no grant, registered outputs clear
      for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 5'(i + 1), 32'd0);
      drive();
      #2;
      chk_reset_outputs("rst0");
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      tb_init = 1'b0;
      rst_n = 1'b1;

      // Round robin with all four held: 0,1,2,3,0,1,2,3
      for (int k = 0; k < 8; k++) begin
         for (int i = 0; i < NREQ; i++)
            if (!pend[i]) set_req(i, 1'($urandom_range(0, 1)), 5'(8 + i), $urandom);
         step();
         chk_eq("rr_seq", obs_gnt, 64'd1 << (k % 4));
      end

      // Pointer wrap after grant to 3: 1010 grants 1 then 3
      pend = '0;
      set_req(1, 1'b0, 5'd12, 32'd0);
      set_req(3, 1'b0, 5'd13, 32'd0);
      step();
      chk_eq("wrap_first", obs_gnt, 64'h2);
      step();
      chk_eq("wrap_second", obs_gnt, 64'h8);
      drain(2);

      // Write then read from requester 0
      set_req(0, 1'b1, 5'd7, 32'hDEADBEEF);
      step();
      set_req(0, 1'b0, 5'd7, 32'd0);
      step();
      drain(2);
      chk_eq("wr_rd_rvalid", obs_rvalid, 64'h1);
      chk_eq("wr_rd_rdata", obs_rdata, 64'hDEADBEEF);

      // Back-to-back RAW across requesters
      set_req(1, 1'b1, 5'd31, 32'h12345678);
      step();
      set_req(2, 1'b0, 5'd31, 32'd0);
      step();
      drain(2);
      chk_eq("raw_rvalid", obs_rvalid, 64'h4);
      chk_eq("raw_rdata", obs_rdata, 64'h12345678);

      // Protected write to address 0 is granted but dropped
      set_req(3, 1'b1, 5'd0, 32'hFFFFFFFF);
      step();
      chk_eq("zp_gnt", obs_gnt, 64'h8);
      set_req(3, 1'b0, 5'd0, 32'd0);
      step();
      drain(2);
      chk_eq("zp_rdata", obs_rdata, 64'(init_val(0)));

      // Random traffic with a few hot addresses to provoke hazards
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!pend[i]) begin
               if ($urandom_range(0, 2) == 0)
                  set_req(i, 1'($urandom_range(0, 1)),
                          $urandom_range(0, 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31)), $urandom);
            end else if ($urandom_range(0, 31) == 0) begin
               pend[i] = 1'b0;
            end
         end
         step();
      end
      drain(2);

      // Reset while a read is in flight
      set_req(0, 1'b0, 5'd5, 32'd0);
      step();
      chk_eq("pre_rst_rd", rf_enable_a, 64'd1);
      set_req(1, 1'b0, 5'd6, 32'd0);
      drive();
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("rst1");
      s1_we = 0; s1_re = 0; s2_re = 0; ptr = 0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 5'(20 + i), 32'd0);
      step();
      chk_eq("post_rst_first", obs_gnt, 64'h1);
      drain(4);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
